zap_shift_stage: RTL and testbench
==================================

Name: zap_shift_stage

Overview:
- Pipelined shift stage sitting between decode/issue and the ALU.
- Accepts operand/shift-type requests on a valid/ready handshake and computes the full ARM shifter-operand result and shifter carry-out, including RRX, which it resolves using the incoming C flag.
- Presents the results registered on a valid/ready output.
- A 2-entry skid buffer keeps o_ready registered (no combinational ready path).

Parameters:
- SHIFT_OPS, 5, number of shift types; the type field is $clog2(SHIFT_OPS) bits wide.
- TAG_W, 6, width of the opaque instruction tag carried alongside each request.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  discard all held entries (pipeline flush)
- i_valid  in  1  request valid
- o_ready  out  1  stage can accept a request
- i_source  in  32  value to shift
- i_amount  in  8  shift amount (register-specified semantics, 0..255)
- i_shift_type  in  $clog2(SHIFT_OPS)  LSL/LSR/ASR/ROR/RORI
- i_carry_flag  in  1  current CPSR C, sampled with the request
- i_tag  in  TAG_W  opaque tag
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_result  out  32  shifted value
- o_carry  out  1  shifter carry-out
- o_rrx  out  1  result is an RRX
- o_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (i_reset=1 at a clock edge): o_valid=0, o_ready=1, o_result=0, o_carry=0, o_rrx=0, o_tag=0, occupancy=0.
- Transfer rules:
  - A request transfers when i_valid && o_ready.
  - A result transfers when o_valid && i_ready.
  - Latency is 1 cycle: the result is visible the cycle after acceptance if the output slot is empty.
- Occupancy FSM:
  - States: EMPTY (0), ONE (1, output slot full), TWO (output slot and skid slot full).
  - EMPTY: accept -> ONE.
  - ONE: accept only -> TWO; drain only -> EMPTY; accept and drain together -> ONE, with the new entry in the output slot.
  - TWO: drain -> ONE, skid entry moves to the output slot.
  - o_ready = (state != TWO), registered.
  - o_valid = (state != EMPTY).
- Computation, performed at accept; a = i_amount, s = i_source, C = i_carry_flag:
  - LSL: a=0 -> s, C. 1..31 -> s<<a, s[32-a]. a=32 -> 0, s[0]. a>32 -> 0, 0.
  - LSR: a=0 -> s, C. 1..31 -> s>>a, s[a-1]. a=32 -> 0, s[31]. a>32 -> 0, 0.
  - ASR: a=0 -> s, C. 1..31 -> arithmetic shift, s[a-1]. a>=32 -> {32{s[31]}}, s[31].
  - ROR:
    - a=0 -> RRX: result {C, s[31:1]}, carry s[0], o_rrx=1.
    - a!=0 and a[4:0]=0 -> s, s[31].
    - otherwise rotate by a[4:0], carry = result[31].
  - RORI: a[4:0]=0 -> s, C. Otherwise rotate by a[4:0], carry = result[31]. Never RRX.
  - Unused type encodings -> s, C, o_rrx=0.
  - o_rrx=0 for every case except ROR a=0.
- Flush and reset priority:
  - i_flush: next state EMPTY; any request presented in the same cycle is dropped.
  - i_reset overrides i_flush.
- Output stability: entry contents are held stable while o_valid && !i_ready.

Optional Feature:
- Macro ZAP_SHIFT_ZERO_FLAG_EN.
- Defined:
  - Adds output o_zero (1 bit), computed at accept as (result == 0) and carried through both slots.
  - Reset value 0.
- Undefined:
  - Port absent; no extra flops.
  - All other behaviour identical.

Decomposition:
- Shared header shtype.vh holds the shift-type localparams: LSL=0, LSR=1, ASR=2, ROR=3, RORI=4.
- The occupancy state encodings belong in a package-level localparam set.
- One sub-module, zap_shift_calc: purely combinational computation of result, carry and rrx.
- Sequential skid/FSM logic stays in zap_shift_stage.

Test Plan:
- LSL s=0x8000_0001, a=1, C=0 -> result 0x0000_0002, carry 1, rrx 0, one cycle after accept.
- ROR s=0x0000_0003, a=0, C=1 -> result 0x8000_0001, carry 1, rrx 1; same request with RORI -> result 0x0000_0003, carry 1 (=C), rrx 0.
- ASR s=0x8000_0000, a=40 -> result 0xFFFF_FFFF, carry 1; LSR s=0x8000_0000, a=32 -> result 0, carry 1; LSL s=1, a=33 -> result 0, carry 0.
- Backpressure: i_ready=0 with 3 back-to-back requests -> o_ready falls after 2 accepts; 3rd held off; with i_ready=1, results arrive in order with the tags intact.
- i_flush asserted in TWO with i_valid=1 -> next cycle o_valid=0, o_ready=1, and the flushed requests never appear.
- i_reset mid-stream -> all outputs 0 and o_ready=1 the next cycle; the first post-reset request completes with latency 1.

Source files
------------

// File: rtl/zap_shift_pkg.sv
// zap_shift_pkg
//   Shared definitions for the zap shift stage: the shift-type encodings from shtype.vh
//   and the skid-buffer occupancy state encodings.
//   No ports (package).
package zap_shift_pkg;

    `include "shtype.vh"

    // Occupancy encodings: number of valid entries held by the stage.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = OCC_EMPTY,
        StOne   = OCC_ONE,
        StTwo   = OCC_TWO
    } occ_state_e;

endpackage

// File: rtl/shtype.vh
// Shift-type encodings shared by the zap shift stage files.
// Included once, inside zap_shift_pkg; other files see these through the package import.
`ifndef ZAP_SHTYPE_VH
`define ZAP_SHTYPE_VH
localparam int unsigned LSL  = 0;
localparam int unsigned LSR  = 1;
localparam int unsigned ASR  = 2;
localparam int unsigned ROR  = 3;
localparam int unsigned RORI = 4;
`endif

// File: rtl/zap_shift_calc.sv
// zap_shift_calc
//   Purely combinational ARM shifter-operand unit (register-specified amount semantics).
//   Ports:
//     i_source      value to shift
//     i_amount      shift amount 0..255
//     i_shift_type  LSL/LSR/ASR/ROR/RORI (unused encodings pass the source through)
//     i_carry_flag  incoming C flag (used for amount 0 and RRX)
//     o_result      shifted value
//     o_carry       shifter carry-out
//     o_rrx         high only for ROR with amount 0
module zap_shift_calc
    import zap_shift_pkg::*;
#(
    parameter int unsigned SHIFT_OPS = 5
) (
    input  logic [31:0]                  i_source,
    input  logic [7:0]                   i_amount,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
    input  logic                         i_carry_flag,
    output logic [31:0]                  o_result,
    output logic                         o_carry,
    output logic                         o_rrx
);

    localparam int unsigned TYPE_W = $clog2(SHIFT_OPS);

    localparam logic [TYPE_W-1:0] T_LSL  = TYPE_W'(LSL);
    localparam logic [TYPE_W-1:0] T_LSR  = TYPE_W'(LSR);
    localparam logic [TYPE_W-1:0] T_ASR  = TYPE_W'(ASR);
    localparam logic [TYPE_W-1:0] T_ROR  = TYPE_W'(ROR);
    localparam logic [TYPE_W-1:0] T_RORI = TYPE_W'(RORI);

    logic [4:0]  w_amt5;
    logic        w_amt_zero;
    logic        w_amt5_zero;
    logic        w_amt_lt32;
    logic        w_amt_eq32;
    logic [32:0] w_lsl;
    logic [32:0] w_lsr;
    logic [32:0] w_asr;
    logic [31:0] w_ror;

    assign w_amt5      = i_amount[4:0];
    assign w_amt_zero  = (i_amount == 8'd0);
    assign w_amt5_zero = (w_amt5 == 5'd0);
    assign w_amt_lt32  = (i_amount[7:5] == 3'd0);
    assign w_amt_eq32  = (i_amount == 8'd32);

    // Extra bit beside the data catches the last bit shifted out (the carry).
    assign w_lsl = {1'b0, i_source} << w_amt5;
    assign w_lsr = {i_source, 1'b0} >> w_amt5;
    assign w_asr = $signed({i_source, 1'b0}) >>> w_amt5;
    // For w_amt5 == 0 the left term shifts by 32 and vanishes, leaving i_source.
    assign w_ror = (i_source >> w_amt5) | (i_source << (6'd32 - {1'b0, w_amt5}));

    always_comb begin
        o_result = i_source;
        o_carry  = i_carry_flag;
        o_rrx    = 1'b0;
        case (i_shift_type)
            T_LSL: begin
                if (w_amt_zero) begin
                    o_result = i_source;
                end else if (w_amt_lt32) begin
                    {o_carry, o_result} = w_lsl;
                end else if (w_amt_eq32) begin
                    o_result = 32'd0;
                    o_carry  = i_source[0];
                end else begin
                    o_result = 32'd0;
                    o_carry  = 1'b0;
                end
            end
            T_LSR: begin
                if (w_amt_zero) begin
                    o_result = i_source;
                end else if (w_amt_lt32) begin
                    {o_result, o_carry} = w_lsr;
                end else if (w_amt_eq32) begin
                    o_result = 32'd0;
                    o_carry  = i_source[31];
                end else begin
                    o_result = 32'd0;
                    o_carry  = 1'b0;
                end
            end
            T_ASR: begin
                if (w_amt_zero) begin
                    o_result = i_source;
                end else if (w_amt_lt32) begin
                    {o_result, o_carry} = w_asr;
                end else begin
                    o_result = {32{i_source[31]}};
                    o_carry  = i_source[31];
                end
            end
            T_ROR: begin
                if (w_amt_zero) begin
                    // RRX: rotate right by one through the carry flag.
                    o_result = {i_carry_flag, i_source[31:1]};
                    o_carry  = i_source[0];
                    o_rrx    = 1'b1;
                end else if (w_amt5_zero) begin
                    o_result = i_source;
                    o_carry  = i_source[31];
                end else begin
                    o_result = w_ror;
                    o_carry  = w_ror[31];
                end
            end
            T_RORI: begin
                if (!w_amt5_zero) begin
                    o_result = w_ror;
                    o_carry  = w_ror[31];
                end
            end
            default: begin
                o_result = i_source;
                o_carry  = i_carry_flag;
            end
        endcase
    end

endmodule

// File: rtl/zap_shift_stage.sv
// zap_shift_stage
//   Registered shift stage between decode/issue and the ALU. Requests are shifted at accept
//   and held in a 2-entry skid buffer (output slot + skid slot) so o_ready is a flop.
//   Optional feature macro: ZAP_SHIFT_ZERO_FLAG_EN adds o_zero (result == 0).
//   Ports:
//     i_clk, i_reset           clock, synchronous active-high reset
//     i_flush                  drop all held entries and any same-cycle request
//     i_valid / o_ready        request handshake
//     i_source, i_amount       operand and shift amount
//     i_shift_type             LSL/LSR/ASR/ROR/RORI
//     i_carry_flag             current C flag, sampled with the request
//     i_tag                    opaque tag carried with the request
//     o_valid / i_ready        result handshake
//     o_result, o_carry, o_rrx shifter result, carry-out, RRX indicator
//     o_zero                   result is zero (only with ZAP_SHIFT_ZERO_FLAG_EN)
//     o_tag                    tag of the presented result
module zap_shift_stage
    import zap_shift_pkg::*;
#(
    parameter int unsigned SHIFT_OPS = 5,
    parameter int unsigned TAG_W     = 6
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [31:0]                  i_source,
    input  logic [7:0]                   i_amount,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
    input  logic                         i_carry_flag,
    input  logic [TAG_W-1:0]             i_tag,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [31:0]                  o_result,
    output logic                         o_carry,
    output logic                         o_rrx,
`ifdef ZAP_SHIFT_ZERO_FLAG_EN
    output logic                         o_zero,
`endif
    output logic [TAG_W-1:0]             o_tag
);

    occ_state_e       r_state;
    occ_state_e       w_state_nxt;
    logic             r_ready;

    logic [31:0]      r_out_result;
    logic             r_out_carry;
    logic             r_out_rrx;
    logic [TAG_W-1:0] r_out_tag;
    logic [31:0]      r_skid_result;
    logic             r_skid_carry;
    logic             r_skid_rrx;
    logic [TAG_W-1:0] r_skid_tag;
`ifdef ZAP_SHIFT_ZERO_FLAG_EN
    logic             r_out_zero;
    logic             r_skid_zero;
    logic             w_calc_zero;
`endif

    logic [31:0]      w_calc_result;
    logic             w_calc_carry;
    logic             w_calc_rrx;

    logic             w_accept;
    logic             w_drain;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;

    zap_shift_calc #(
        .SHIFT_OPS (SHIFT_OPS)
    ) u_calc (
        .i_source     (i_source),
        .i_amount     (i_amount),
        .i_shift_type (i_shift_type),
        .i_carry_flag (i_carry_flag),
        .o_result     (w_calc_result),
        .o_carry      (w_calc_carry),
        .o_rrx        (w_calc_rrx)
    );

`ifdef ZAP_SHIFT_ZERO_FLAG_EN
    assign w_calc_zero = (w_calc_result == 32'd0);
`endif

    assign w_accept = i_valid && r_ready;
    assign w_drain  = (r_state != StEmpty) && i_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        if (i_flush) begin
            w_state_nxt = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_nxt = StOne;
                        w_load_out  = 1'b1;
                    end
                end
                StOne: begin
                    if (w_accept && w_drain) begin
                        w_load_out = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = StTwo;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = StEmpty;
                    end
                end
                StTwo: begin
                    // o_ready is low here, so no accept can coincide with the drain.
                    if (w_drain) begin
                        w_state_nxt   = StOne;
                        w_skid_to_out = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StEmpty;
            r_ready       <= 1'b1;
            r_out_result  <= 32'd0;
            r_out_carry   <= 1'b0;
            r_out_rrx     <= 1'b0;
            r_out_tag     <= '0;
            r_skid_result <= 32'd0;
            r_skid_carry  <= 1'b0;
            r_skid_rrx    <= 1'b0;
            r_skid_tag    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Ready is derived from the next state so it is valid straight out of a flop.
            r_ready <= (w_state_nxt != StTwo);
            if (w_load_out) begin
                r_out_result <= w_calc_result;
                r_out_carry  <= w_calc_carry;
                r_out_rrx    <= w_calc_rrx;
                r_out_tag    <= i_tag;
            end else if (w_skid_to_out) begin
                r_out_result <= r_skid_result;
                r_out_carry  <= r_skid_carry;
                r_out_rrx    <= r_skid_rrx;
                r_out_tag    <= r_skid_tag;
            end
            if (w_load_skid) begin
                r_skid_result <= w_calc_result;
                r_skid_carry  <= w_calc_carry;
                r_skid_rrx    <= w_calc_rrx;
                r_skid_tag    <= i_tag;
            end
        end
    end

`ifdef ZAP_SHIFT_ZERO_FLAG_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_zero  <= 1'b0;
            r_skid_zero <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_out_zero <= w_calc_zero;
            end else if (w_skid_to_out) begin
                r_out_zero <= r_skid_zero;
            end
            if (w_load_skid) begin
                r_skid_zero <= w_calc_zero;
            end
        end
    end

    assign o_zero = r_out_zero;
`endif

    assign o_ready  = r_ready;
    assign o_valid  = (r_state != StEmpty);
    assign o_result = r_out_result;
    assign o_carry  = r_out_carry;
    assign o_rrx    = r_out_rrx;
    assign o_tag    = r_out_tag;

endmodule

// File: tb/tb_zap_shift_stage.sv
// Testbench for zap_shift_stage: directed steps, bit-serial reference shifter, scoreboard queue.
module tb_zap_shift_stage;

    localparam int unsigned SHIFT_OPS = 5;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned TYPE_W    = $clog2(SHIFT_OPS);

    localparam logic [TYPE_W-1:0] T_LSL  = 3'd0;
    localparam logic [TYPE_W-1:0] T_LSR  = 3'd1;
    localparam logic [TYPE_W-1:0] T_ASR  = 3'd2;
    localparam logic [TYPE_W-1:0] T_ROR  = 3'd3;
    localparam logic [TYPE_W-1:0] T_RORI = 3'd4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       source;
    logic [7:0]        amount;
    logic [TYPE_W-1:0] shift_type;
    logic              carry_flag;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_carry;
    logic              rsp_rrx;
    logic [TAG_W-1:0]  rsp_tag;
`ifdef ZAP_SHIFT_ZERO_FLAG_EN
    logic              rsp_zero;
`endif

    always #5 clk = ~clk;

    zap_shift_stage #(
        .SHIFT_OPS (SHIFT_OPS),
        .TAG_W     (TAG_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_flush      (flush),
        .i_valid      (req_valid),
        .o_ready      (req_ready),
        .i_source     (source),
        .i_amount     (amount),
        .i_shift_type (shift_type),
        .i_carry_flag (carry_flag),
        .i_tag        (req_tag),
        .o_valid      (rsp_valid),
        .i_ready      (rsp_ready),
        .o_result     (rsp_result),
        .o_carry      (rsp_carry),
        .o_rrx        (rsp_rrx),
`ifdef ZAP_SHIFT_ZERO_FLAG_EN
        .o_zero       (rsp_zero),
`endif
        .o_tag        (rsp_tag)
    );

    typedef struct {
        logic [31:0]      res;
        logic             car;
        logic             rrx;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   last_acc;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference shifter: moves one bit per step, tracking the last bit shifted out.
    function automatic exp_t model(input logic [31:0] s, input logic [7:0] a,
                                   input logic [TYPE_W-1:0] t, input logic c,
                                   input logic [TAG_W-1:0] tag);
        exp_t        e;
        logic [31:0] r;
        logic        k;
        r     = s;
        k     = c;
        e.rrx = 1'b0;
        case (t)
            T_LSL: for (int i = 0; i < int'(a); i++) begin k = r[31]; r = r << 1; end
            T_LSR: for (int i = 0; i < int'(a); i++) begin k = r[0]; r = r >> 1; end
            T_ASR: for (int i = 0; i < int'(a); i++) begin k = r[0]; r = {r[31], r[31:1]}; end
            T_ROR: begin
                if (a == 8'd0) begin
                    k     = s[0];
                    r     = {c, s[31:1]};
                    e.rrx = 1'b1;
                end else begin
                    for (int i = 0; i < int'(a); i++) begin k = r[0]; r = {r[0], r[31:1]}; end
                end
            end
            T_RORI: for (int i = 0; i < int'(a[4:0]); i++) begin k = r[0]; r = {r[0], r[31:1]}; end
            default: ;
        endcase
        e.res = r;
        e.car = k;
        e.tag = tag;
        return e;
    endfunction

    task automatic set_req(input logic [31:0] s, input logic [7:0] a, input logic [TYPE_W-1:0] t,
                           input logic c, input logic [TAG_W-1:0] tg);
        req_valid  = 1'b1;
        source     = s;
        amount     = a;
        shift_type = t;
        carry_flag = c;
        req_tag    = tg;
        pend       = model(s, a, t, c, tg);
    endtask

    task automatic set_req_k(input logic [31:0] s, input logic [7:0] a, input logic [TYPE_W-1:0] t,
                             input logic c, input logic [TAG_W-1:0] tg,
                             input logic [31:0] res, input logic car, input logic rrx);
        req_valid  = 1'b1;
        source     = s;
        amount     = a;
        shift_type = t;
        carry_flag = c;
        req_tag    = tg;
        pend.res   = res;
        pend.car   = car;
        pend.rrx   = rrx;
        pend.tag   = tg;
    endtask

    // Called at a negedge: resolve this cycle's handshakes, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        last_acc = 1'b0;
        if (!reset) begin
            if (rsp_valid && rsp_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", rsp_result, e.res);
                    check("carry", 32'(rsp_carry), 32'(e.car));
                    check("rrx", 32'(rsp_rrx), 32'(e.rrx));
                    check("tag", 32'(rsp_tag), 32'(e.tag));
`ifdef ZAP_SHIFT_ZERO_FLAG_EN
                    check("zero", 32'(rsp_zero), 32'(e.res == 32'd0));
`endif
                end
            end
            if (req_valid && req_ready && !flush) begin
                sb.push_back(pend);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (reset || flush) sb.delete();
    endtask

    task automatic send_hold();
        for (int k = 0; k < 20 && !last_acc; k++) tick();
        check("accept_timeout", 32'(last_acc), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain_all();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        check("drain_timeout", 32'(sb.size()), 32'd0);
        check("idle_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] amt_tab [6];
        logic [7:0] a;
        amt_tab = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd255};
        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        source     = '0;
        amount     = '0;
        shift_type = '0;
        carry_flag = 1'b0;
        req_tag    = '0;
        pend       = model(32'd0, 8'd0, T_LSL, 1'b0, '0);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_result", rsp_result, 32'd0);
        check("rst_carry", 32'(rsp_carry), 32'd0);
        check("rst_rrx", 32'(rsp_rrx), 32'd0);
        check("rst_tag", 32'(rsp_tag), 32'd0);

        // Latency-1 LSL, then the directed corner cases back to back.
        rsp_ready = 1'b1;
        set_req_k(32'h8000_0001, 8'd1, T_LSL, 1'b0, 6'd1, 32'h0000_0002, 1'b1, 1'b0);
        tick();
        req_valid = 1'b0;
        check("lat1_valid", 32'(rsp_valid), 32'd1);
        tick();
        set_req_k(32'h0000_0003, 8'd0, T_ROR, 1'b1, 6'd2, 32'h8000_0001, 1'b1, 1'b1);
        tick();
        set_req_k(32'h0000_0003, 8'd0, T_RORI, 1'b1, 6'd3, 32'h0000_0003, 1'b1, 1'b0);
        tick();
        set_req_k(32'h8000_0000, 8'd40, T_ASR, 1'b0, 6'd4, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        set_req_k(32'h8000_0000, 8'd32, T_LSR, 1'b0, 6'd5, 32'h0000_0000, 1'b1, 1'b0);
        tick();
        set_req_k(32'h0000_0001, 8'd33, T_LSL, 1'b0, 6'd6, 32'h0000_0000, 1'b0, 1'b0);
        tick();
        drain_all();

        // Random mix with boundary amounts, unused encodings and random backpressure.
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 7) < 6) ? amt_tab[$urandom_range(0, 5)] : 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                set_req($urandom, a, TYPE_W'($urandom_range(0, 7)), 1'($urandom), 6'($urandom));
            end else begin
                req_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain_all();

        // Backpressure: two accepts fill the buffer, the third is held off.
        rsp_ready = 1'b0;
        set_req(32'h1234_5678, 8'd4, T_ROR, 1'b0, 6'd10);
        tick();
        check("bp_acc1", 32'(last_acc), 32'd1);
        set_req(32'hF000_000F, 8'd8, T_ASR, 1'b1, 6'd11);
        tick();
        check("bp_acc2", 32'(last_acc), 32'd1);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_valid", 32'(rsp_valid), 32'd1);
        set_req(32'h0000_00FF, 8'd7, T_LSL, 1'b0, 6'd12);
        tick();
        check("bp_held_off", 32'(last_acc), 32'd0);
        tick();
        check("bp_still_full", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        send_hold();
        drain_all();

        // Flush while full, with a request presented in the same cycle.
        rsp_ready = 1'b0;
        set_req(32'hAAAA_5555, 8'd1, T_LSR, 1'b0, 6'd20);
        tick();
        set_req(32'h5555_AAAA, 8'd2, T_LSL, 1'b0, 6'd21);
        tick();
        check("fl_full", 32'(req_ready), 32'd0);
        set_req(32'h0F0F_0F0F, 8'd3, T_RORI, 1'b1, 6'd22);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("fl_valid", 32'(rsp_valid), 32'd0);
        check("fl_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        repeat (3) tick();
        check("fl_quiet", 32'(rsp_valid), 32'd0);

        // Reset mid-stream, then a fresh request completes with latency 1.
        rsp_ready = 1'b0;
        set_req(32'hDEAD_BEEF, 8'd5, T_ROR, 1'b1, 6'd30);
        tick();
        set_req(32'hCAFE_F00D, 8'd9, T_LSR, 1'b0, 6'd31);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 1'b0;
        check("mr_valid", 32'(rsp_valid), 32'd0);
        check("mr_ready", 32'(req_ready), 32'd1);
        check("mr_result", rsp_result, 32'd0);
        check("mr_carry", 32'(rsp_carry), 32'd0);
        check("mr_rrx", 32'(rsp_rrx), 32'd0);
        check("mr_tag", 32'(rsp_tag), 32'd0);
        rsp_ready = 1'b1;
        set_req_k(32'h0000_00F0, 8'd4, T_LSR, 1'b0, 6'd32, 32'h0000_000F, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        check("mr_lat1", 32'(rsp_valid), 32'd1);
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
